// File: rtl/shifter_pkg.sv
// Shared mode encoding for the pipelined barrel shifter.
package shifter_pkg;

    typedef logic [1:0] shift_mode_t;

    localparam shift_mode_t MODE_SLL = 2'b00;
    localparam shift_mode_t MODE_SRL = 2'b01;
    localparam shift_mode_t MODE_SRA = 2'b10;
    localparam shift_mode_t MODE_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditional shift by a fixed distance DIST, then a stallable register.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DIST    = 1,
    parameter int unsigned SEL_BIT = 0,
    parameter int unsigned SHW     = 5,
    parameter int unsigned TAGW    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              up_valid,
    input  logic [WIDTH-1:0]  up_data,
    input  shift_mode_t       up_mode,
    input  logic [SHW-1:0]    up_shamt,
    input  logic [TAGW-1:0]   up_tag,
    output logic              valid,
    output logic [WIDTH-1:0]  data,
    output shift_mode_t       mode,
    output logic [SHW-1:0]    shamt,
    output logic [TAGW-1:0]   tag,
    output logic [WIDTH-1:0]  shifted
);

    // SRA fills from the stage input's MSB, which every earlier stage preserved.
    always_comb begin
        shifted = up_data;
        if (up_shamt[SEL_BIT]) begin
            unique case (up_mode)
                MODE_SLL: shifted = up_data << DIST;
                MODE_SRL: shifted = up_data >> DIST;
                MODE_SRA: shifted = $unsigned($signed(up_data) >>> DIST);
                MODE_ROR: shifted = (up_data >> DIST) | (up_data << (WIDTH - DIST));
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            mode  <= MODE_SLL;
            shamt <= '0;
            tag   <= '0;
        end else if (en) begin
            valid <= up_valid;
            data  <= shifted;
            mode  <= up_mode;
            shamt <= up_shamt;
            tag   <= up_tag;
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, largest distance first.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH),
    parameter int unsigned TAGW  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_zero
);

    localparam int unsigned L = SHW;

    logic              st_valid   [L];
    logic [WIDTH-1:0]  st_data    [L];
    shift_mode_t       st_mode    [L];
    logic [SHW-1:0]    st_shamt   [L];
    logic [TAGW-1:0]   st_tag     [L];
    logic [WIDTH-1:0]  st_shifted [L];
    logic [L-1:0]      adv;
    logic              zero_q;

    // A stage may advance unless it and every stage downstream of it is full
    // while the output is stalled; this lets bubbles collapse.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        adv      = '0;
        for (int k = int'(L) - 1; k >= 0; k--) begin
            all_full = all_full & st_valid[k];
            adv[k]   = ~all_full | out_ready;
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic              up_valid;
        logic [WIDTH-1:0]  up_data;
        shift_mode_t       up_mode;
        logic [SHW-1:0]    up_shamt;
        logic [TAGW-1:0]   up_tag;

        if (k == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = in_data;
            assign up_mode  = in_mode;
            assign up_shamt = in_shamt;
            assign up_tag   = in_tag;
        end else begin : g_rest
            assign up_valid = st_valid[k-1];
            assign up_data  = st_data[k-1];
            assign up_mode  = st_mode[k-1];
            assign up_shamt = st_shamt[k-1];
            assign up_tag   = st_tag[k-1];
        end

        shift_stage #(
            .WIDTH   (WIDTH),
            .DIST    (int'(1) << (L - 1 - k)),
            .SEL_BIT (L - 1 - k),
            .SHW     (SHW),
            .TAGW    (TAGW)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .en       (adv[k]),
            .up_valid (up_valid),
            .up_data  (up_data),
            .up_mode  (up_mode),
            .up_shamt (up_shamt),
            .up_tag   (up_tag),
            .valid    (st_valid[k]),
            .data     (st_data[k]),
            .mode     (st_mode[k]),
            .shamt    (st_shamt[k]),
            .tag      (st_tag[k]),
            .shifted  (st_shifted[k])
        );
    end

    // Zero flag is registered alongside the last stage so it tracks out_data exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else if (adv[L-1]) begin
            zero_q <= (st_shifted[L-1] == '0);
        end
    end

    assign in_ready  = adv[0] & ~reset;
    assign out_valid = st_valid[L-1];
    assign out_data  = st_data[L-1];
    assign out_tag   = st_tag[L-1];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and random checks of pipelined_shifter against a single-shot shift model.
module tb_pipelined_shifter;

    localparam int L = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_zero;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          acc_cnt = 0;
    bit          lat_chk = 1'b1;
    logic [31:0] hold;

    pipelined_shifter #(
        .WIDTH (32),
        .SHW   (5),
        .TAGW  (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    always #5 clock = ~clock;

    // Single-shot reference: whole shift in one arithmetic step.
    function automatic logic [31:0] model(input logic [31:0] d, input int sh, input logic [1:0] m);
        logic [63:0] w;
        case (m)
            2'd0: return d << sh;
            2'd1: return d >> sh;
            2'd2: begin
                w = {{32{d[31]}}, d};
                w = w >> sh;
                return w[31:0];
            end
            default: begin
                w = {d, d};
                w = w >> sh;
                return w[31:0];
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One cycle: drive, sample settled handshake before the edge, score, advance to negedge.
    task automatic tick(input logic iv, input logic [31:0] d, input logic [4:0] sh,
                        input logic [1:0] m, input logic [4:0] tg, input logic ordy,
                        input logic [31:0] exp);
        exp_t e;
        in_valid  = iv;
        in_data   = d;
        in_shamt  = sh;
        in_mode   = m;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        if (out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                check("data", 64'(out_data), 64'(e.data));
                check("tag", 64'(out_tag), 64'(e.tag));
                check("zero", 64'(out_zero), 64'(e.data == 32'd0));
                if (lat_chk) check("latency", 64'(cyc - e.t), 64'(L));
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            q.push_back('{exp, tg, cyc});
            acc_cnt++;
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic send_rand(input logic ordy);
        logic [31:0] d;
        logic [4:0]  sh;
        logic [1:0]  m;
        logic [4:0]  tg;
        d  = $urandom;
        sh = 5'($urandom_range(0, 31));
        m  = 2'($urandom_range(0, 3));
        tg = 5'($urandom_range(0, 31));
        tick(1'b1, d, sh, m, tg, ordy, model(d, int'(sh), m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 5'd0, 2'd0, 5'd0, 1'b1, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_out_zero", 64'(out_zero), 64'd0);
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Single op per mode
        tick(1'b1, 32'h80000F0F, 5'd4, 2'd0, 5'd1, 1'b1, 32'h0000F0F0);
        idle(6);
        tick(1'b1, 32'h80000F0F, 5'd4, 2'd1, 5'd2, 1'b1, 32'h080000F0);
        idle(6);
        tick(1'b1, 32'h80000F0F, 5'd4, 2'd2, 5'd3, 1'b1, 32'hF80000F0);
        idle(6);
        tick(1'b1, 32'h80000F0F, 5'd4, 2'd3, 5'd4, 1'b1, 32'hF80000F0);
        drain();

        // Boundary shift amounts
        for (int m = 0; m < 4; m++)
            tick(1'b1, 32'h12345678, 5'd0, 2'(m), 5'(m + 8), 1'b1, 32'h12345678);
        tick(1'b1, 32'h80000000, 5'd31, 2'd2, 5'd12, 1'b1, 32'hFFFFFFFF);
        tick(1'b1, 32'h80000000, 5'd31, 2'd1, 5'd13, 1'b1, 32'h00000001);
        tick(1'b1, 32'h00000001, 5'd31, 2'd0, 5'd14, 1'b1, 32'h80000000);
        tick(1'b1, 32'h00000001, 5'd1, 2'd3, 5'd15, 1'b1, 32'h80000000);
        // Zero flag
        tick(1'b1, 32'h00000001, 5'd1, 2'd1, 5'd16, 1'b1, 32'h00000000);
        drain();

        // Back-to-back streaming
        for (int i = 0; i < 20; i++) begin
            send_rand(1'b1);
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        drain();

        // Backpressure: pipeline fills to exactly L, output held
        lat_chk = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) send_rand(1'b0);
        check("bp_accepted", 64'(acc_cnt), 64'(L));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        hold = out_data;
        check("bp_head_data", 64'(hold), 64'(q[0].data));
        for (int i = 0; i < 3; i++) begin
            send_rand(1'b0);
            check("bp_hold_data", 64'(out_data), 64'(hold));
            check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        check("bp_accepted_after_hold", 64'(acc_cnt), 64'(L));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        idle(L);
        check("bp_drained_in_order", 64'(q.size()), 64'd0);
        lat_chk = 1'b1;

        // Reset with ops in flight
        for (int i = 0; i < 3; i++) send_rand(1'b1);
        reset = 1'b1;
        #1;
        check("reset_in_ready_inflight", 64'(in_ready), 64'd0);
        idle(1);
        check("reset_flush_valid", 64'(out_valid), 64'd0);
        check("reset_flush_data", 64'(out_data), 64'd0);
        check("reset_flush_zero", 64'(out_zero), 64'd0);
        q.delete();
        reset = 1'b0;
        idle(10);

        // Post-reset sanity
        for (int i = 0; i < 6; i++) send_rand(1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter for the processor ALU/execute path.
- Generalises the fixed 32-bit arithmetic-right shifter in three ways: parametrised width, four shift modes, and one registered stage per shift bit.
- Valid/ready handshake on input and output; a per-stage bubble-collapsing stall.
- Sustains one operation per cycle when the output is not back-pressured.

Parameters:
- WIDTH, 32: data width. Must be a power of two, at least 2.
- SHW, $clog2(WIDTH): shift-amount width, which is also the pipeline depth L.
- TAGW, 5: width of the sideband tag carried with each operation (e.g. destination register).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts an operation this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- in_mode  in  2  shift mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAGW  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAGW  tag of the result.
- out_zero  out  1  out_data == 0.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high, on ports clock and reset.
  - While reset is high at a rising edge, every stage valid bit clears and out_data, out_tag and out_zero clear to 0.
  - In-flight operations are discarded, with no output.
  - in_ready is 0 while reset is asserted.
- Pipeline structure:
  - L stages, numbered 0..L-1.
  - Stage k applies a shift of 2^(L-1-k) when shamt bit (L-1-k) is 1, and passes data through otherwise. The largest shift comes first, as in the existing shifter.
  - Each stage registers: valid, data, mode, shamt, tag.
  - Stage L-1's register drives out_*.
- Mode semantics per stage (distance d):
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, fill with data[WIDTH-1] of the stage input. This is equivalent to the sign of the original operand.
  - ROR: rotate right, bits shifted out re-enter at the MSB.
- Result definitions:
  - The composite result equals the single-shot operation by in_shamt.
  - shamt = 0 gives out_data = in_data in all modes.
  - No modulo behaviour is needed beyond SHW bits, because shamt is already < WIDTH.
- Latency and throughput:
  - An operation accepted at edge N (in_valid & in_ready) is presented with out_valid = 1 after edge N+L-1.
  - That is L cycles of register delay, counting the input capture as stage 0.
  - Minimum latency is L cycles. Throughput is 1 per cycle.
- Handshake (stage advance rule):
  - adv[L-1] = !valid[L-1] | out_ready.
  - adv[k] = !valid[k] | adv[k+1].
  - in_ready = adv[0].
  - A stage whose adv is 0 holds all its fields.
  - valid[k+1] loads valid[k] when adv[k+1] is 1.
- Output stability: while out_valid = 1 and out_ready = 0, out_data, out_tag and out_zero are held stable. in_valid is not required to stay stable upstream.
- Bubbles: empty stages are filled while the output is stalled. Up to L operations can be in flight, and in_ready drops only when all L stages are full and out_ready = 0.
- Simultaneous events:
  - A full pipeline with out_ready = 1 and in_valid = 1 accepts a new operation in the same cycle the oldest leaves.
  - Reset overrides all handshake activity.
- out_zero is computed combinationally in stage L-1 from its input data and is registered with that stage.

Decomposition:
- Package shifter_pkg:
  - Mode constants MODE_SLL = 2'b00, MODE_SRL = 2'b01, MODE_SRA = 2'b10, MODE_ROR = 2'b11.
  - A typedef for the 2-bit mode.
- Sub-module shift_stage:
  - Parameters WIDTH, DIST, SEL_BIT.
  - Contents: one combinational shift by DIST for all four modes, plus its registered valid/data/mode/shamt/tag fields and its stall enable.
  - pipelined_shifter instantiates L of them in a generate loop, with DIST = 2^(L-1-k), and produces the adv chain and out_zero.

Test Plan (WIDTH = 32, L = 5):
1. Single op per mode, out_ready = 1. Operand 0x80000F0F, shamt 4:
   - SLL -> 0x0000F0F0
   - SRL -> 0x080000F0
   - SRA -> 0xF80000F0
   - ROR -> 0xF80000F0
   - Each result appears exactly 5 cycles after acceptance, with the tag preserved.
2. Boundary shift amounts:
   - shamt 0 on 0x12345678 -> 0x12345678 in all modes.
   - shamt 31, SRA on 0x80000000 -> 0xFFFFFFFF.
   - shamt 31, SRL on 0x80000000 -> 0x00000001.
   - shamt 31, SLL on 0x00000001 -> 0x80000000.
   - shamt 1, ROR on 0x00000001 -> 0x80000000.
3. Back-to-back streaming: 20 random ops on consecutive cycles with out_ready = 1 -> 20 results on consecutive cycles, in order, all matching the reference model, with in_ready constantly 1.
4. Backpressure: hold out_ready = 0 while feeding ops -> exactly 5 accepted, then in_ready = 0 and out_data held stable. Release out_ready -> all 5 drain in order, and in_ready returns to 1 the same cycle.
5. Zero flag and reset:
   - SLL 0x00000001 by 31 -> out_zero = 0.
   - SRL 0x00000001 by 1 -> out_zero = 1.
   - Assert reset with 3 ops in flight -> next cycle out_valid = 0 and out_data = 0, and none of the 3 ops ever emerge.
